// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM encoding, op codes and default widths.
package mem_pkg;

   localparam int MEM_DATA_W = 32;
   localparam int MEM_ADDR_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic OP_RD = 1'b0;
   localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/mem_array.sv
// Word storage: synchronous write, combinational read, no reset (contents survive Reset).
module mem_array
   import mem_pkg::*;
#(
   parameter int DATA_W = MEM_DATA_W,
   parameter int DEPTH  = 256,
   parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] r_mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata = r_mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one MemRead/MemWrite, waits WAIT_STATES cycles,
// then pulses MemReady for one cycle (returning MemData on reads).
module mem_responder
   import mem_pkg::*;
#(
   parameter int DATA_W      = MEM_DATA_W,
   parameter int ADDR_W      = MEM_ADDR_W,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] WriteData,
   output logic [DATA_W-1:0] MemData,
   output logic              MemReady,
   output logic              Busy,
   output logic              Error,
   output logic              Overrun
);

   localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]      WS_LOAD = 4'(WAIT_STATES);
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   state_t              r_state;
   state_t              w_state_next;
   logic [3:0]          r_cnt;
   logic [3:0]          w_cnt_next;
   logic                r_op;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_mem_data;
   logic                r_err_illegal;
   logic                r_overrun;

   logic                w_accepting;
   logic                w_accept;
   logic                w_illegal;
   logic                w_resp;
   logic                w_oor;
   logic                w_we;
   logic                w_resp_rd;
   logic [DATA_W-1:0]   w_rdata;
   logic [DATA_W-1:0]   w_rd_value;

   assign w_accepting = (r_state == ST_IDLE) || (r_state == ST_RESP);
   assign w_accept    = w_accepting && (MemRead ^ MemWrite);
   assign w_illegal   = w_accepting && MemRead && MemWrite;
   assign w_resp      = (r_state == ST_RESP);
   assign w_oor       = ({1'b0, r_addr} >= DEPTH_L);
   assign w_resp_rd   = w_resp && (r_op == OP_RD);
   assign w_rd_value  = w_oor ? '0 : w_rdata;

   // Reset gates the commit so a reset landing on the RESP edge drops the write.
   assign w_we = w_resp && (r_op == OP_WR) && !w_oor && !Reset;

   mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (w_we),
      .waddr (r_addr[IDX_W-1:0]),
      .wdata (r_wdata),
      .raddr (r_addr[IDX_W-1:0]),
      .rdata (w_rdata)
   );

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         ST_IDLE, ST_RESP: begin
            if (w_accept) begin
               w_cnt_next   = WS_LOAD;
               w_state_next = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_WAIT: begin
            w_cnt_next = r_cnt - 4'd1;
            if (r_cnt <= 4'd1) begin
               w_state_next = ST_RESP;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         r_state       <= ST_IDLE;
         r_cnt         <= 4'd0;
         r_op          <= OP_RD;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_mem_data    <= '0;
         r_err_illegal <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_cnt         <= w_cnt_next;
         r_err_illegal <= w_illegal;
         r_overrun     <= (r_state == ST_WAIT) && (MemRead || MemWrite);
         if (w_accept) begin
            r_op    <= MemWrite ? OP_WR : OP_RD;
            r_addr  <= Addr;
            r_wdata <= WriteData;
         end
         if (w_resp_rd) begin
            r_mem_data <= w_rd_value;
         end
      end
   end

   // Read data is presented in the RESP cycle itself and held afterwards.
   assign MemData  = w_resp_rd ? w_rd_value : r_mem_data;
   assign MemReady = w_resp;
   assign Busy     = (r_state != ST_IDLE);
   assign Error    = r_err_illegal || (w_resp && w_oor);
   assign Overrun  = r_overrun;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: one responder with WAIT_STATES=2 and one with WAIT_STATES=0.
`timescale 1ns/1ps
module tb_mem_responder;

   logic        clk = 1'b0;
   int          errs = 0;
   int          checks = 0;

   logic        rst2 = 1'b1, rd2 = 1'b0, wr2 = 1'b0;
   logic [15:0] addr2 = '0;
   logic [31:0] wd2 = '0;
   logic [31:0] md2;
   logic        rdy2, busy2, err2, ovr2;

   logic        rst0 = 1'b1, rd0 = 1'b0, wr0 = 1'b0;
   logic [15:0] addr0 = '0;
   logic [31:0] wd0 = '0;
   logic [31:0] md0;
   logic        rdy0, busy0, err0, ovr0;

   always #5 clk = ~clk;

   mem_responder #(.DATA_W(32), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(2)) u_dut2 (
      .clk(clk), .Reset(rst2), .MemRead(rd2), .MemWrite(wr2), .Addr(addr2),
      .WriteData(wd2), .MemData(md2), .MemReady(rdy2), .Busy(busy2),
      .Error(err2), .Overrun(ovr2)
   );

   mem_responder #(.DATA_W(32), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .Reset(rst0), .MemRead(rd0), .MemWrite(wr0), .Addr(addr0),
      .WriteData(wd0), .MemData(md0), .MemReady(rdy0), .Busy(busy0),
      .Error(err0), .Overrun(ovr0)
   );

   // Issue one request on the WAIT_STATES=2 instance and wait (bounded) for MemReady.
   // Entered and left 1ns after a rising edge; leaves while MemReady is high.
   task automatic xact2(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] data,
                        output logic err);
      rd2 = rd; wr2 = wr; addr2 = a; wd2 = d;
      @(posedge clk); #1;
      rd2 = 1'b0; wr2 = 1'b0;
      lat = -1; data = '0; err = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (rdy2) begin
            lat = k; data = md2; err = err2;
            break;
         end
         @(posedge clk); #1;
      end
      $display("xact rd=%0b wr=%0b addr=%0d wdata=%h -> lat=%0d rdata=%h err=%0b",
               rd, wr, a, d, lat, data, err);
   endtask

   task automatic test_reset;
      rst2 = 1'b1; rst0 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({rdy2, busy2, err2, ovr2} !== 4'b0000) begin
         errs++; $display("FAIL reset_flags_ws2: got %b expected 0000", {rdy2, busy2, err2, ovr2});
      end
      checks++;
      if (md2 !== 32'h0) begin
         errs++; $display("FAIL reset_memdata_ws2: got %h expected 00000000", md2);
      end
      checks++;
      if ({rdy0, busy0, err0, ovr0} !== 4'b0000) begin
         errs++; $display("FAIL reset_flags_ws0: got %b expected 0000", {rdy0, busy0, err0, ovr0});
      end
      checks++;
      if (md0 !== 32'h0) begin
         errs++; $display("FAIL reset_memdata_ws0: got %h expected 00000000", md0);
      end
      rst2 = 1'b0; rst0 = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({rdy2, busy2, rdy0, busy0} !== 4'b0000) begin
         errs++; $display("FAIL reset_idle_after_release: got %b expected 0000", {rdy2, busy2, rdy0, busy0});
      end
   endtask

   task automatic test_write_read;
      wr2 = 1'b1; addr2 = 16'd5; wd2 = 32'hDEADBEEF;
      @(posedge clk); #1;
      wr2 = 1'b0;
      checks++;
      if ({rdy2, busy2} !== 2'b01) begin
         errs++; $display("FAIL wr_accept_wait: got rdy/busy=%b expected 01", {rdy2, busy2});
      end
      @(posedge clk); #1;
      checks++;
      if (rdy2 !== 1'b0) begin
         errs++; $display("FAIL wr_wait2: got rdy=%b expected 0", rdy2);
      end
      @(posedge clk); #1;
      checks++;
      if ({rdy2, err2} !== 2'b10) begin
         errs++; $display("FAIL wr_ready_n3: got rdy/err=%b expected 10", {rdy2, err2});
      end
      $display("xact wr addr=5 data=deadbeef ready at N+3");
      rd2 = 1'b1; addr2 = 16'd5;
      @(posedge clk); #1;
      rd2 = 1'b0;
      checks++;
      if ({rdy2, busy2} !== 2'b01) begin
         errs++; $display("FAIL rd_b2b_accept: got rdy/busy=%b expected 01", {rdy2, busy2});
      end
      @(posedge clk); #1;
      checks++;
      if (rdy2 !== 1'b0) begin
         errs++; $display("FAIL rd_b2b_wait: got rdy=%b expected 0", rdy2);
      end
      @(posedge clk); #1;
      checks++;
      if (rdy2 !== 1'b1 || md2 !== 32'hDEADBEEF) begin
         errs++; $display("FAIL rd_after_wr_n6: got rdy=%b data=%h expected 1 deadbeef", rdy2, md2);
      end
      $display("xact rd addr=5 data=%h ready at N+6", md2);
      @(posedge clk); #1;
      checks++;
      if ({rdy2, busy2} !== 2'b00 || md2 !== 32'hDEADBEEF) begin
         errs++; $display("FAIL rd_hold: got rdy/busy=%b data=%h expected 00 deadbeef", {rdy2, busy2}, md2);
      end
   endtask

   task automatic test_ws0_back_to_back;
      logic [31:0] vals [3];
      vals[0] = 32'hA1A1_0001; vals[1] = 32'hB2B2_0002; vals[2] = 32'hC3C3_0003;
      wr0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         addr0 = 16'(i + 1); wd0 = vals[i];
         @(posedge clk); #1;
         checks++;
         if (rdy0 !== 1'b1) begin
            errs++; $display("FAIL ws0_write%0d_ready: got %b expected 1", i + 1, rdy0);
         end
         $display("xact ws0 wr addr=%0d data=%h rdy=%b", i + 1, vals[i], rdy0);
      end
      wr0 = 1'b0; rd0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         addr0 = 16'(i + 1);
         @(posedge clk); #1;
         checks++;
         if (rdy0 !== 1'b1 || md0 !== vals[i]) begin
            errs++; $display("FAIL ws0_read%0d: got rdy=%b data=%h expected 1 %h", i + 1, rdy0, md0, vals[i]);
         end
         $display("xact ws0 rd addr=%0d data=%h rdy=%b", i + 1, md0, rdy0);
      end
      rd0 = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (rdy0 !== 1'b0 || md0 !== vals[2]) begin
         errs++; $display("FAIL ws0_idle_hold: got rdy=%b data=%h expected 0 %h", rdy0, md0, vals[2]);
      end
   endtask

   task automatic test_illegal;
      int lat; logic [31:0] data; logic err;
      xact2(1'b0, 1'b1, 16'd9, 32'h1111_2222, lat, data, err);
      rd2 = 1'b1; wr2 = 1'b1; addr2 = 16'd9; wd2 = 32'h0BAD_0BAD;
      @(posedge clk); #1;
      rd2 = 1'b0; wr2 = 1'b0;
      checks++;
      if ({err2, rdy2, busy2} !== 3'b100) begin
         errs++; $display("FAIL illegal_pulse: got err/rdy/busy=%b expected 100", {err2, rdy2, busy2});
      end
      $display("xact illegal rd+wr addr=9 err=%b", err2);
      @(posedge clk); #1;
      checks++;
      if ({err2, rdy2} !== 2'b00) begin
         errs++; $display("FAIL illegal_one_cycle: got err/rdy=%b expected 00", {err2, rdy2});
      end
      xact2(1'b1, 1'b0, 16'd9, 32'h0, lat, data, err);
      checks++;
      if (lat !== 2 || data !== 32'h1111_2222 || err !== 1'b0) begin
         errs++; $display("FAIL illegal_array_unchanged: got lat=%0d data=%h err=%b expected 2 11112222 0", lat, data, err);
      end
   endtask

   task automatic test_overrun;
      int lat; logic [31:0] data; logic err;
      xact2(1'b0, 1'b1, 16'd12, 32'hCAFE_0012, lat, data, err);
      @(posedge clk); #1;
      rd2 = 1'b1; addr2 = 16'd12;
      @(posedge clk); #1;
      rd2 = 1'b1; addr2 = 16'd5;
      @(posedge clk); #1;
      rd2 = 1'b0;
      checks++;
      if ({ovr2, rdy2} !== 2'b10) begin
         errs++; $display("FAIL overrun_pulse: got ovr/rdy=%b expected 10", {ovr2, rdy2});
      end
      @(posedge clk); #1;
      checks++;
      if ({ovr2, rdy2} !== 2'b01 || md2 !== 32'hCAFE_0012) begin
         errs++; $display("FAIL overrun_orig_completes: got ovr/rdy=%b data=%h expected 01 cafe0012", {ovr2, rdy2}, md2);
      end
      $display("xact rd addr=12 with overrun data=%h", md2);
   endtask

   task automatic test_out_of_range;
      int lat; logic [31:0] data; logic err;
      xact2(1'b1, 1'b0, 16'd300, 32'h0, lat, data, err);
      checks++;
      if (lat !== 2 || data !== 32'h0 || err !== 1'b1) begin
         errs++; $display("FAIL oor_read: got lat=%0d data=%h err=%b expected 2 00000000 1", lat, data, err);
      end
      xact2(1'b0, 1'b1, 16'd44, 32'h4444_0044, lat, data, err);
      xact2(1'b0, 1'b1, 16'd300, 32'hDEAD_012C, lat, data, err);
      checks++;
      if (lat !== 2 || err !== 1'b1) begin
         errs++; $display("FAIL oor_write_flags: got lat=%0d err=%b expected 2 1", lat, err);
      end
      xact2(1'b1, 1'b0, 16'd44, 32'h0, lat, data, err);
      checks++;
      if (data !== 32'h4444_0044 || err !== 1'b0) begin
         errs++; $display("FAIL oor_write_dropped: got data=%h err=%b expected 44440044 0", data, err);
      end
   endtask

   task automatic test_reset_mid;
      int lat; logic [31:0] data; logic err; logic saw_ready;
      xact2(1'b0, 1'b1, 16'd7, 32'h7777_0000, lat, data, err);
      xact2(1'b1, 1'b0, 16'd7, 32'h0, lat, data, err);
      checks++;
      if (data !== 32'h7777_0000) begin
         errs++; $display("FAIL rstmid_setup: got %h expected 77770000", data);
      end
      @(posedge clk); #1;
      wr2 = 1'b1; addr2 = 16'd7; wd2 = 32'h1234_5678;
      @(posedge clk); #1;
      wr2 = 1'b0; rst2 = 1'b1;
      @(posedge clk); #1;
      rst2 = 1'b0;
      checks++;
      if ({rdy2, busy2} !== 2'b00 || md2 !== 32'h0) begin
         errs++; $display("FAIL rstmid_state: got rdy/busy=%b data=%h expected 00 00000000", {rdy2, busy2}, md2);
      end
      saw_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         if (rdy2) saw_ready = 1'b1;
      end
      checks++;
      if (saw_ready !== 1'b0) begin
         errs++; $display("FAIL rstmid_no_ready: got MemReady after reset, expected none");
      end
      xact2(1'b1, 1'b0, 16'd7, 32'h0, lat, data, err);
      checks++;
      if (lat !== 2 || data !== 32'h7777_0000) begin
         errs++; $display("FAIL rstmid_write_dropped: got lat=%0d data=%h expected 2 77770000", lat, data);
      end
      @(posedge clk); #1;
      wr2 = 1'b1; addr2 = 16'd7; wd2 = 32'h9999_AAAA;
      @(posedge clk); #1;
      wr2 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (rdy2 !== 1'b1) begin
         errs++; $display("FAIL rstresp_in_resp: got rdy=%b expected 1", rdy2);
      end
      rst2 = 1'b1;
      @(posedge clk); #1;
      rst2 = 1'b0;
      @(posedge clk); #1;
      xact2(1'b1, 1'b0, 16'd7, 32'h0, lat, data, err);
      checks++;
      if (data !== 32'h7777_0000) begin
         errs++; $display("FAIL rstresp_write_dropped: got %h expected 77770000", data);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_write_read();
      test_ws0_back_to_back();
      test_illegal();
      test_overrun();
      test_out_of_range();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
